// File: rtl/wb_pdm_pkg.sv
// wb_pdm_pkg: register map offsets and CTRL bit positions shared by the PDM controller.
// The CTRL word address equals CHANNELS and is computed in the top module.
package wb_pdm_pkg;
    localparam int unsigned LEVEL_BASE       = 0;
    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_SYNC_BIT    = 1;
    localparam int unsigned CTRL_PENDING_LSB = 8;
endpackage

// File: rtl/wb_pdm_ctrl_slot.sv
// pdm_channel_slot: one PDM channel with shadow/active levels, pending flag and the
// registered compare against the shared counter.
// Optional macro PDM_SLEW_EN: on each transfer point active steps 1 LSB toward shadow.
module pdm_channel_slot #(
    parameter int unsigned BIT_RESOLUTION = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_i,
    input  logic [BIT_RESOLUTION-1:0] wdat_i,
    input  logic                      xfer_i,
    input  logic                      en_i,
    input  logic [BIT_RESOLUTION-1:0] cnt_i,
    output logic [BIT_RESOLUTION-1:0] shadow_o,
    output logic                      pending_o,
    output logic                      pdm_o
);
    logic [BIT_RESOLUTION-1:0] shadow_q, active_q, active_d;
    logic                      pending_q, pending_d, pdm_q;

`ifdef PDM_SLEW_EN
    // Slew: move active one LSB toward shadow at each transfer point.
    always_comb begin
        active_d = active_q;
        if (xfer_i) begin
            if (active_q < shadow_q)
                active_d = active_q + BIT_RESOLUTION'(1);
            else if (active_q > shadow_q)
                active_d = active_q - BIT_RESOLUTION'(1);
        end
    end
`else
    // Direct load: active takes the (pre-write) shadow at each transfer point.
    always_comb begin
        active_d = active_q;
        if (xfer_i)
            active_d = shadow_q;
    end
`endif

    // Pending: set by a write (wins over a same-edge transfer), cleared once active reaches shadow.
    always_comb begin
        pending_d = pending_q;
        if (wr_i)
            pending_d = 1'b1;
        else if (xfer_i && (active_d == shadow_q))
            pending_d = 1'b0;
    end

    // Level state and registered duty compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pdm_q     <= 1'b0;
        end else begin
            if (wr_i)
                shadow_q <= wdat_i;
            active_q  <= active_d;
            pending_q <= pending_d;
            pdm_q     <= en_i & (active_q > cnt_i);
        end
    end

    assign shadow_o  = shadow_q;
    assign pending_o = pending_q;
    assign pdm_o     = pdm_q;
endmodule

// File: rtl/wb_pdm_ctrl.sv
// wb_pdm_ctrl: Wishbone B4 pipelined slave owning a bank of PDM channels, the shared
// period counter, CTRL (EN/SYNC/PENDING) and the one-cycle ack/read path.
// Optional macro PDM_SLEW_EN: transfers only at period boundaries with 1 LSB slew.
module wb_pdm_ctrl
    import wb_pdm_pkg::*;
#(
    parameter int unsigned BIT_RESOLUTION = 8,
    parameter int unsigned CHANNELS       = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [$clog2(CHANNELS+1)-1:0] wb_adr_i,
    input  logic [31:0]                   wb_dat_i,
    output logic [31:0]                   wb_dat_o,
    output logic                          wb_ack_o,
    output logic                          wb_stall_o,
    output logic [CHANNELS-1:0]           pdm_o
);
    localparam int unsigned AW = $clog2(CHANNELS+1);
    localparam logic [AW-1:0] CTRL_ADR = AW'(CHANNELS);

    logic                                    req, ctrl_wr, en_d, boundary, xfer;
    logic                                    en_q, sync_q, ack_q;
    logic [BIT_RESOLUTION-1:0]               cnt_q, cnt_d;
    logic [31:0]                             rdata, dat_q;
    logic [CHANNELS-1:0]                     pending_w;
    logic [CHANNELS-1:0][BIT_RESOLUTION-1:0] shadow_w;
    logic                                    unused_dat;

    assign req        = wb_cyc_i & wb_stb_i;
    assign ctrl_wr    = req & wb_we_i & (wb_adr_i == CTRL_ADR);
    assign en_d       = ctrl_wr ? wb_dat_i[CTRL_EN_BIT] : en_q;
    assign boundary   = en_q & (&cnt_q);
    assign unused_dat = ^wb_dat_i[31:BIT_RESOLUTION];
    assign wb_stall_o = 1'b0;

    // Counter runs only while EN stays set; enabling or disabling restarts it from 0.
    always_comb begin
        cnt_d = '0;
        if (en_q && en_d)
            cnt_d = cnt_q + BIT_RESOLUTION'(1);
    end

`ifdef PDM_SLEW_EN
    assign xfer = boundary;
`else
    assign xfer = sync_q ? boundary : 1'b1;
`endif

    // Counter, CTRL bits and bus response registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            sync_q <= 1'b0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            if (ctrl_wr)
                sync_q <= wb_dat_i[CTRL_SYNC_BIT];
            ack_q  <= req;
            dat_q  <= (req && !wb_we_i) ? rdata : '0;
        end
    end

    // Read mux sampled before this edge's writes, so same-cycle reads see old values.
    always_comb begin
        rdata = '0;
        if (wb_adr_i == CTRL_ADR) begin
            rdata[CTRL_EN_BIT]                     = en_q;
            rdata[CTRL_SYNC_BIT]                   = sync_q;
            rdata[CTRL_PENDING_LSB +: CHANNELS]    = pending_w;
        end
        for (int i = 0; i < CHANNELS; i++)
            if (wb_adr_i == AW'(LEVEL_BASE + i))
                rdata = 32'(shadow_w[i]);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pdm_channel_slot #(.BIT_RESOLUTION(BIT_RESOLUTION)) u_slot (
            .clk_i     (wb_clk_i),
            .rst_ni    (wb_rst_ni),
            .wr_i      (req & wb_we_i & (wb_adr_i == AW'(LEVEL_BASE + g))),
            .wdat_i    (wb_dat_i[BIT_RESOLUTION-1:0]),
            .xfer_i    (xfer),
            .en_i      (en_q),
            .cnt_i     (cnt_q),
            .shadow_o  (shadow_w[g]),
            .pending_o (pending_w[g]),
            .pdm_o     (pdm_o[g])
        );
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
endmodule
